// File: rtl/crypt_arbiter_if.sv
// Request/response and encryptor-core signals shared by the two crypto
// clients, the encryptor core and crypt_arbiter.
interface crypt_arbiter_if #(
    parameter int DATA_W = 128
);
    logic              req_valid_0;
    logic              req_ready_0;
    logic [DATA_W-1:0] req_plaintext_0;
    logic [DATA_W-1:0] req_key_0;
    logic              rsp_valid_0;
    logic              rsp_ready_0;
    logic [DATA_W-1:0] rsp_ciphertext_0;
    logic              rsp_err_0;

    logic              req_valid_1;
    logic              req_ready_1;
    logic [DATA_W-1:0] req_plaintext_1;
    logic [DATA_W-1:0] req_key_1;
    logic              rsp_valid_1;
    logic              rsp_ready_1;
    logic [DATA_W-1:0] rsp_ciphertext_1;
    logic              rsp_err_1;

    logic              core_load;
    logic [DATA_W-1:0] core_plaintext;
    logic [DATA_W-1:0] core_key;
    logic [DATA_W-1:0] core_ciphertext;
    logic              core_done;

    logic              busy;

    // Arbiter side
    modport slave (
        input  req_valid_0, req_plaintext_0, req_key_0, rsp_ready_0,
        input  req_valid_1, req_plaintext_1, req_key_1, rsp_ready_1,
        input  core_ciphertext, core_done,
        output req_ready_0, rsp_valid_0, rsp_ciphertext_0, rsp_err_0,
        output req_ready_1, rsp_valid_1, rsp_ciphertext_1, rsp_err_1,
        output core_load, core_plaintext, core_key, busy
    );

    // Clients and encryptor core side
    modport master (
        output req_valid_0, req_plaintext_0, req_key_0, rsp_ready_0,
        output req_valid_1, req_plaintext_1, req_key_1, rsp_ready_1,
        output core_ciphertext, core_done,
        input  req_ready_0, rsp_valid_0, rsp_ciphertext_0, rsp_err_0,
        input  req_ready_1, rsp_valid_1, rsp_ciphertext_1, rsp_err_1,
        input  core_load, core_plaintext, core_key, busy
    );
endinterface

// File: rtl/crypt_arbiter.sv
// Round-robin sharing of one encryptor core between two requesters.
// Optional WAIT watchdog with error response: define CRYPT_TIMEOUT_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   IDLE    | arbitrating, req_ready to the grant winner
//   LOAD    | core_load pulse, core_done ignored
//   WAIT    | waiting for core_done (or watchdog abort)
//   RESP    | rsp_valid to owner until rsp_ready
module crypt_arbiter #(
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 64
) (
    input logic            clk,
    input logic            rst,
    crypt_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              owner;
    logic              grant_0;
    logic              grant_1;
    logic              rsp_ack;
    logic              core_load_q;
    logic              busy_q;
    logic              rsp_valid_0_q;
    logic              rsp_valid_1_q;
    logic [DATA_W-1:0] core_pt_q;
    logic [DATA_W-1:0] core_key_q;
    logic [DATA_W-1:0] result_q;

`ifdef CRYPT_TIMEOUT_EN
    logic [15:0]       wdog_q;
    logic              rsp_err_0_q;
    logic              rsp_err_1_q;
`endif

    // On contention the requester that did not win last time is served
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (bus.req_valid_0 && bus.req_valid_1) begin
            if (last_grant) grant_0 = 1'b1;
            else            grant_1 = 1'b1;
        end else if (bus.req_valid_0) begin
            grant_0 = 1'b1;
        end else if (bus.req_valid_1) begin
            grant_1 = 1'b1;
        end
    end

    assign rsp_ack = owner ? bus.rsp_ready_1 : bus.rsp_ready_0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            core_load_q   <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            core_pt_q     <= '0;
            core_key_q    <= '0;
            result_q      <= '0;
`ifdef CRYPT_TIMEOUT_EN
            wdog_q        <= '0;
            rsp_err_0_q   <= 1'b0;
            rsp_err_1_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_0 || grant_1) begin
                        owner       <= grant_1;
                        last_grant  <= grant_1;
                        core_pt_q   <= grant_1 ? bus.req_plaintext_1 : bus.req_plaintext_0;
                        core_key_q  <= grant_1 ? bus.req_key_1 : bus.req_key_0;
                        core_load_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    core_load_q <= 1'b0;
`ifdef CRYPT_TIMEOUT_EN
                    wdog_q      <= '0;
`endif
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done in the same cycle as the watchdog expiry wins
                    if (bus.core_done) begin
                        result_q      <= bus.core_ciphertext;
                        rsp_valid_0_q <= ~owner;
                        rsp_valid_1_q <= owner;
`ifdef CRYPT_TIMEOUT_EN
                        rsp_err_0_q   <= 1'b0;
                        rsp_err_1_q   <= 1'b0;
`endif
                        state         <= ST_RESP;
                    end
`ifdef CRYPT_TIMEOUT_EN
                    else if (wdog_q == 16'(TIMEOUT - 1)) begin
                        result_q      <= '0;
                        rsp_valid_0_q <= ~owner;
                        rsp_valid_1_q <= owner;
                        rsp_err_0_q   <= ~owner;
                        rsp_err_1_q   <= owner;
                        state         <= ST_RESP;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ack) begin
                        rsp_valid_0_q <= 1'b0;
                        rsp_valid_1_q <= 1'b0;
`ifdef CRYPT_TIMEOUT_EN
                        rsp_err_0_q   <= 1'b0;
                        rsp_err_1_q   <= 1'b0;
`endif
                        busy_q        <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready_0      = (state == ST_IDLE) && grant_0;
    assign bus.req_ready_1      = (state == ST_IDLE) && grant_1;
    assign bus.rsp_valid_0      = rsp_valid_0_q;
    assign bus.rsp_valid_1      = rsp_valid_1_q;
    assign bus.rsp_ciphertext_0 = result_q;
    assign bus.rsp_ciphertext_1 = result_q;
    assign bus.core_load        = core_load_q;
    assign bus.core_plaintext   = core_pt_q;
    assign bus.core_key         = core_key_q;
    assign bus.busy             = busy_q;

`ifdef CRYPT_TIMEOUT_EN
    assign bus.rsp_err_0 = rsp_err_0_q;
    assign bus.rsp_err_1 = rsp_err_1_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign bus.rsp_err_0  = 1'b0;
    assign bus.rsp_err_1  = 1'b0;
`endif
endmodule

// File: tb/tb_crypt_arbiter.sv
// Bench for crypt_arbiter: directed scenarios plus randomized jobs checked
// against a job-level model (round-robin winner, XOR core, fixed latency).
module tb_crypt_arbiter;
    localparam int DW      = 128;
    localparam int TMO     = 8;
    localparam int CORE_LAT = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crypt_arbiter_if #(.DATA_W(DW)) bus();

    crypt_arbiter #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Encryptor model: result = plaintext ^ key, CORE_LAT cycles after load
    logic [3:0]    cnt = '0;
    logic [DW-1:0] cm_ct = '0;
    bit            core_dead = 1'b0;
    bit            done_in_load = 1'b0;

    always @(posedge clk) begin
        if (bus.core_load) begin
            cnt   <= 4'(CORE_LAT);
            cm_ct <= bus.core_plaintext ^ bus.core_key;
        end else if (cnt != 0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign bus.core_done       = !core_dead && ((cnt == 4'd1) || (done_in_load && bus.core_load));
    assign bus.core_ciphertext = (cnt == 4'd1) ? cm_ct : {DW{1'b1}};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit m_last;
    int t_acc;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
        bus.rsp_ready_0 = 1'b0; bus.rsp_ready_1 = 1'b0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        m_last = 1'b1;
        step();
    endtask

    // Present a request pattern in IDLE; model picks the winner
    task automatic issue(input bit v0, input bit v1,
                         input logic [DW-1:0] p0, input logic [DW-1:0] k0,
                         input logic [DW-1:0] p1, input logic [DW-1:0] k1,
                         output int w);
        bus.req_valid_0 = v0; bus.req_plaintext_0 = p0; bus.req_key_0 = k0;
        bus.req_valid_1 = v1; bus.req_plaintext_1 = p1; bus.req_key_1 = k1;
        #1;
        if (v0 && v1) w = m_last ? 0 : 1;
        else          w = v0 ? 0 : 1;
        chk("req_ready_0", bus.req_ready_0, (w == 0));
        chk("req_ready_1", bus.req_ready_1, (w == 1));
        t_acc  = cyc;
        m_last = (w == 1);
        step();
        if (w == 0) bus.req_valid_0 = 1'b0;
        else        bus.req_valid_1 = 1'b0;
        chk("core_load_pulse", bus.core_load, 1);
        chk("core_plaintext", bus.core_plaintext, (w == 0) ? p0 : p1);
        chk("core_key", bus.core_key, (w == 0) ? k0 : k1);
    endtask

    task automatic await_rsp(input int r, input int limit, output int lat);
        step();
        chk("core_load_single", bus.core_load, 0);
        for (int i = 0; i < limit && !((r == 0) ? bus.rsp_valid_0 : bus.rsp_valid_1); i++) step();
        chk("rsp_valid_arrive", (r == 0) ? bus.rsp_valid_0 : bus.rsp_valid_1, 1);
        chk("rsp_other_low", (r == 0) ? bus.rsp_valid_1 : bus.rsp_valid_0, 0);
        lat = cyc - t_acc;
    endtask

    task automatic finish_rsp(input int r, input int hold, input logic [DW-1:0] exp_ct, input bit exp_err);
        chk("rsp_ciphertext", (r == 0) ? bus.rsp_ciphertext_0 : bus.rsp_ciphertext_1, exp_ct);
        chk("rsp_err", (r == 0) ? bus.rsp_err_0 : bus.rsp_err_1, exp_err);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("rsp_hold_valid", (r == 0) ? bus.rsp_valid_0 : bus.rsp_valid_1, 1);
            chk("rsp_hold_ct", (r == 0) ? bus.rsp_ciphertext_0 : bus.rsp_ciphertext_1, exp_ct);
        end
        if (r == 0) bus.rsp_ready_0 = 1'b1; else bus.rsp_ready_1 = 1'b1;
        step();
        bus.rsp_ready_0 = 1'b0; bus.rsp_ready_1 = 1'b0;
        chk("rsp_done_valid", (r == 0) ? bus.rsp_valid_0 : bus.rsp_valid_1, 0);
        chk("rsp_done_busy", bus.busy, 0);
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int w, lat, hold, seen;
        logic [DW-1:0] p0, k0, p1, k1, ct_hold;
        logic [1:0] vv;

        bus.req_valid_0 = 1'b0; bus.req_plaintext_0 = '0; bus.req_key_0 = '0; bus.rsp_ready_0 = 1'b0;
        bus.req_valid_1 = 1'b0; bus.req_plaintext_1 = '0; bus.req_key_1 = '0; bus.rsp_ready_1 = 1'b0;

        do_reset();
        chk("rst_busy", bus.busy, 0);
        chk("rst_core_load", bus.core_load, 0);
        chk("rst_rsp_valid_0", bus.rsp_valid_0, 0);
        chk("rst_rsp_valid_1", bus.rsp_valid_1, 0);
        chk("rst_core_pt", bus.core_plaintext, 0);
        chk("rst_core_key", bus.core_key, 0);
        chk("rst_rsp_ct", bus.rsp_ciphertext_0, 0);
        chk("rst_rsp_err", bus.rsp_err_0, 0);

        // Single job, response ready already high
        bus.rsp_ready_0 = 1'b1;
        issue(1, 0, 1407, 25, 0, 0, w);
        await_rsp(0, 40, lat);
        chk("single_latency", lat, 12);
        finish_rsp(0, 0, 1382, 0);

        // Contention after reset: req0 first, then req1
        do_reset();
        issue(1, 1, 285, 1293, 7, 7, w);
        await_rsp(0, 40, lat);
        finish_rsp(0, 0, 1040, 0);
        issue(0, 1, 0, 0, 7, 7, w);
        await_rsp(1, 40, lat);
        finish_rsp(1, 0, 0, 0);
        issue(1, 1, 11, 22, 33, 44, w);
        chk("rr_after_req1", w, 0);
        await_rsp(0, 40, lat);
        finish_rsp(0, 1, 11 ^ 22, 0);

        // Backpressure on req1 with req0 pending (req1 wins: last grant was req0)
        p0 = rnd128(); k0 = rnd128(); p1 = rnd128(); k1 = rnd128();
        issue(1, 1, p0, k0, p1, k1, w);
        await_rsp(1, 40, lat);
        ct_hold = bus.rsp_ciphertext_1;
        chk("bp_ct", ct_hold, p1 ^ k1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", bus.rsp_valid_1, 1);
            chk("bp_ct_stable", bus.rsp_ciphertext_1, p1 ^ k1);
            chk("bp_core_pt_held", bus.core_plaintext, p1);
            chk("bp_req0_blocked", bus.req_ready_0, 0);
            step();
        end
        bus.rsp_ready_1 = 1'b1;
        #1;
        chk("bp_req0_blocked_hs", bus.req_ready_0, 0);
        step();
        bus.rsp_ready_1 = 1'b0;
        chk("bp_rsp_dropped", bus.rsp_valid_1, 0);
        issue(1, 0, p0, k0, 0, 0, w);
        await_rsp(0, 40, lat);
        finish_rsp(0, 0, p0 ^ k0, 0);

        // Core shows done while loading: must not shortcut WAIT
        done_in_load = 1'b1;
        p1 = rnd128(); k1 = rnd128();
        issue(0, 1, 0, 0, p1, k1, w);
        await_rsp(1, 40, lat);
        chk("done_in_load_latency", lat, 12);
        finish_rsp(1, 0, p1 ^ k1, 0);
        done_in_load = 1'b0;

        // Randomized jobs against the round-robin / XOR model
        for (int n = 0; n < 30; n++) begin
            vv = 2'($urandom_range(1, 3));
            p0 = rnd128(); k0 = rnd128(); p1 = rnd128(); k1 = rnd128();
            hold = $urandom_range(0, 3);
            issue(vv[0], vv[1], p0, k0, p1, k1, w);
            bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
            await_rsp(w, 40, lat);
            chk("rand_latency", lat, 12);
            finish_rsp(w, hold, (w == 0) ? (p0 ^ k0) : (p1 ^ k1), 0);
        end

        // Reset in WAIT: job dropped, stale core_done ignored
        do_reset();
        issue(1, 0, 5, 6, 0, 0, w);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_last = 1'b1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_rsp_valid_0", bus.rsp_valid_0, 0);
        chk("midrst_rsp_valid_1", bus.rsp_valid_1, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.rsp_valid_0 || bus.rsp_valid_1 || bus.busy) seen++;
        end
        chk("midrst_stale_done", seen, 0);
        p1 = rnd128(); k1 = rnd128();
        issue(0, 1, 0, 0, p1, k1, w);
        await_rsp(1, 40, lat);
        chk("midrst_latency", lat, 12);
        finish_rsp(1, 0, p1 ^ k1, 0);

        // Core never finishes
        core_dead = 1'b1;
        issue(1, 0, 77, 88, 0, 0, w);
`ifdef CRYPT_TIMEOUT_EN
        await_rsp(0, 40, lat);
        chk("timeout_latency", lat, 2 + TMO);
        finish_rsp(0, 1, 0, 1);
`else
        for (int i = 0; i < 100; i++) step();
        chk("no_timeout_busy", bus.busy, 1);
        chk("no_timeout_rsp", bus.rsp_valid_0, 0);
        do_reset();
`endif
        core_dead = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end
endmodule
